// File: rtl/tx_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tx_frame_sequencer                                            |
// | Purpose  : VLC transmitter frame/burst sequencer: PHY reset, guard,      |
// |            short/long preamble windows and paced data-symbol requests.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tx_frame_sequencer #(
    parameter int PHY_RST_CYCLES  = 10,
    parameter int TS_DELAY_CYCLES = 64,
    parameter int SHORT_LEN       = 320,
    parameter int LONG_LEN        = 288,
    parameter int SYM_PERIOD      = 80,
    parameter int IFG_CYCLES      = 32,
    parameter int NSYM_W          = 16,
    parameter int NFRM_W          = 8
) (
    input  logic              SYS_CLK,
    input  logic              S_MCU_RST,
    input  logic              SEND_ENABLE,
    input  logic [NSYM_W-1:0] N_SYM,
    input  logic [NFRM_W-1:0] N_FRAME,
    input  logic              ABORT,
    output logic              PHY_RST,
    output logic              SHORT_ACK,
    output logic              LONG_ACK,
    output logic              DATA_REQ,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              BURST_DONE,
    output logic [NFRM_W-1:0] FRAME_IDX
);

    localparam int c_max_ab  = (PHY_RST_CYCLES > TS_DELAY_CYCLES) ? PHY_RST_CYCLES : TS_DELAY_CYCLES;
    localparam int c_max_cd  = (SHORT_LEN > LONG_LEN) ? SHORT_LEN : LONG_LEN;
    localparam int c_max_dur = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_ph_w    = (c_max_dur > 1) ? $clog2(c_max_dur) : 1;
    localparam int c_slot_w  = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;

    localparam logic [c_ph_w-1:0]   c_ph_one     = c_ph_w'(1);
    localparam logic [c_ph_w-1:0]   c_phy_last   = c_ph_w'(PHY_RST_CYCLES - 1);
    localparam logic [c_ph_w-1:0]   c_ts_last    = c_ph_w'(TS_DELAY_CYCLES - 1);
    localparam logic [c_ph_w-1:0]   c_short_last = c_ph_w'(SHORT_LEN - 1);
    localparam logic [c_ph_w-1:0]   c_long_last  = c_ph_w'(LONG_LEN - 1);
    localparam logic [c_ph_w-1:0]   c_ifg_last   = c_ph_w'(IFG_CYCLES - 1);
    localparam logic [c_slot_w-1:0] c_slot_one   = c_slot_w'(1);
    localparam logic [c_slot_w-1:0] c_slot_last  = c_slot_w'(SYM_PERIOD - 1);
    localparam logic [NSYM_W-1:0]   c_sym_one    = NSYM_W'(1);
    localparam logic [NFRM_W-1:0]   c_frm_one    = NFRM_W'(1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_phy   = 3'd1;
    localparam logic [2:0] c_st_ts    = 3'd2;
    localparam logic [2:0] c_st_short = 3'd3;
    localparam logic [2:0] c_st_long  = 3'd4;
    localparam logic [2:0] c_st_data  = 3'd5;
    localparam logic [2:0] c_st_fend  = 3'd6;
    localparam logic [2:0] c_st_ifg   = 3'd7;

    logic [2:0]          r_state,   w_state;
    logic [c_ph_w-1:0]   r_phase,   w_phase;
    logic [c_slot_w-1:0] r_slot,    w_slot;
    logic [NSYM_W-1:0]   r_sym,     w_sym;
    logic [NSYM_W-1:0]   r_n_sym,   w_n_sym;
    logic [NFRM_W-1:0]   r_n_frame, w_n_frame;
    logic [NFRM_W-1:0]   r_idx,     w_idx;
    logic r_phy_rst, r_short_ack, r_long_ack, r_data_req;
    logic r_busy, r_frame_done, r_burst_done;

    always_comb begin
        w_state   = r_state;
        w_phase   = '0;
        w_slot    = r_slot;
        w_sym     = r_sym;
        w_n_sym   = r_n_sym;
        w_n_frame = r_n_frame;
        w_idx     = r_idx;
        case (r_state)
            c_st_idle: begin
                if (SEND_ENABLE && !ABORT) begin
                    w_state   = c_st_phy;
                    w_n_sym   = N_SYM;
                    w_n_frame = (N_FRAME == '0) ? c_frm_one : N_FRAME;
                    w_idx     = '0;
                end
            end
            c_st_phy: begin
                if (r_phase == c_phy_last) w_state = c_st_ts;
                else                       w_phase = r_phase + c_ph_one;
            end
            c_st_ts: begin
                if (r_phase == c_ts_last) w_state = c_st_short;
                else                      w_phase = r_phase + c_ph_one;
            end
            c_st_short: begin
                if (r_phase == c_short_last) w_state = c_st_long;
                else                         w_phase = r_phase + c_ph_one;
            end
            c_st_long: begin
                if (r_phase == c_long_last) begin
                    w_state = (r_n_sym == '0) ? c_st_fend : c_st_data;
                    w_slot  = '0;
                    w_sym   = '0;
                end else begin
                    w_phase = r_phase + c_ph_one;
                end
            end
            c_st_data: begin
                // r_sym counts completed slots; the frame ends on the last slot's final cycle
                if (r_slot == c_slot_last) begin
                    w_slot = '0;
                    if (r_sym == r_n_sym - c_sym_one) w_state = c_st_fend;
                    else                              w_sym   = r_sym + c_sym_one;
                end else begin
                    w_slot = r_slot + c_slot_one;
                end
            end
            c_st_fend: begin
                if (r_idx == r_n_frame - c_frm_one) begin
                    w_state = c_st_idle;
                end else begin
                    w_state = c_st_ifg;
                    w_idx   = r_idx + c_frm_one;
                end
            end
            c_st_ifg: begin
                if (r_phase == c_ifg_last) w_state = c_st_short;
                else                       w_phase = r_phase + c_ph_one;
            end
            default: w_state = c_st_idle;
        endcase
        if (ABORT && (r_state != c_st_idle)) begin
            w_state = c_st_idle;
            w_phase = '0;
            w_slot  = '0;
            w_sym   = '0;
            w_idx   = '0;
        end
    end

    // Outputs are decoded from the next-state values so they register alongside the state
    always_ff @(posedge SYS_CLK or posedge S_MCU_RST) begin
        if (S_MCU_RST) begin
            r_state      <= c_st_idle;
            r_phase      <= '0;
            r_slot       <= '0;
            r_sym        <= '0;
            r_n_sym      <= '0;
            r_n_frame    <= '0;
            r_idx        <= '0;
            r_phy_rst    <= 1'b0;
            r_short_ack  <= 1'b0;
            r_long_ack   <= 1'b0;
            r_data_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_phase      <= w_phase;
            r_slot       <= w_slot;
            r_sym        <= w_sym;
            r_n_sym      <= w_n_sym;
            r_n_frame    <= w_n_frame;
            r_idx        <= w_idx;
            r_phy_rst    <= (w_state == c_st_phy);
            r_short_ack  <= (w_state == c_st_short);
            r_long_ack   <= (w_state == c_st_long);
            r_data_req   <= (w_state == c_st_data) && (w_slot == '0);
            r_busy       <= (w_state != c_st_idle);
            r_frame_done <= (w_state == c_st_fend);
            r_burst_done <= (w_state == c_st_fend) && (w_idx == w_n_frame - c_frm_one);
        end
    end

    assign PHY_RST    = r_phy_rst;
    assign SHORT_ACK  = r_short_ack;
    assign LONG_ACK   = r_long_ack;
    assign DATA_REQ   = r_data_req;
    assign BUSY       = r_busy;
    assign FRAME_DONE = r_frame_done;
    assign BURST_DONE = r_burst_done;
    assign FRAME_IDX  = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tx_frame_sequencer                                         |
// | Purpose  : Self-checking bench; expected waveforms come from a segment    |
// |            timeline model of the frame/burst schedule.                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_tx_frame_sequencer;

    typedef struct packed {
        logic       phy;
        logic       sh;
        logic       lg;
        logic       req;
        logic       busy;
        logic       fd;
        logic       bd;
        logic [7:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic a_send, a_abort, b_send, b_abort;
    logic [15:0] a_nsym, b_nsym;
    logic [7:0]  a_nframe, b_nframe;
    logic a_phy, a_sh, a_lg, a_req, a_busy, a_fd, a_bd;
    logic b_phy, b_sh, b_lg, b_req, b_busy, b_fd, b_bd;
    logic [7:0] a_idx, b_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tx_frame_sequencer dut_a (
        .SYS_CLK(clk), .S_MCU_RST(rst), .SEND_ENABLE(a_send), .N_SYM(a_nsym),
        .N_FRAME(a_nframe), .ABORT(a_abort), .PHY_RST(a_phy), .SHORT_ACK(a_sh),
        .LONG_ACK(a_lg), .DATA_REQ(a_req), .BUSY(a_busy), .FRAME_DONE(a_fd),
        .BURST_DONE(a_bd), .FRAME_IDX(a_idx)
    );

    tx_frame_sequencer #(
        .PHY_RST_CYCLES(1), .TS_DELAY_CYCLES(1), .SHORT_LEN(1), .LONG_LEN(1),
        .SYM_PERIOD(1), .IFG_CYCLES(1), .NSYM_W(16), .NFRM_W(8)
    ) dut_b (
        .SYS_CLK(clk), .S_MCU_RST(rst), .SEND_ENABLE(b_send), .N_SYM(b_nsym),
        .N_FRAME(b_nframe), .ABORT(b_abort), .PHY_RST(b_phy), .SHORT_ACK(b_sh),
        .LONG_ACK(b_lg), .DATA_REQ(b_req), .BUSY(b_busy), .FRAME_DONE(b_fd),
        .BURST_DONE(b_bd), .FRAME_IDX(b_idx)
    );

    function automatic exp_t got_a();
        exp_t g;
        g = {a_phy, a_sh, a_lg, a_req, a_busy, a_fd, a_bd, a_idx};
        return g;
    endfunction

    function automatic exp_t got_b();
        exp_t g;
        g = {b_phy, b_sh, b_lg, b_req, b_busy, b_fd, b_bd, b_idx};
        return g;
    endfunction

    // Expected outputs t cycles after the start edge, laid out as a sequence of segments
    function automatic exp_t model(int t, int ns, int nf, int p_phy, int p_ts, int p_sh,
                                   int p_lg, int p_sp, int p_ifg);
        exp_t e;
        int u, flen, per, k, r;
        e = '0;
        if (nf == 0) nf = 1;
        if (t <= p_phy) begin
            e.phy = 1'b1; e.busy = 1'b1;
            return e;
        end
        if (t <= p_phy + p_ts) begin
            e.busy = 1'b1;
            return e;
        end
        u    = t - 1 - p_phy - p_ts;
        flen = p_sh + p_lg + ns * p_sp + 1;
        per  = flen + p_ifg;
        k    = u / per;
        r    = u % per;
        if (k > nf - 1 || (k == nf - 1 && r >= flen)) begin
            e.idx = 8'(nf - 1);
            return e;
        end
        e.busy = 1'b1;
        e.idx  = 8'(k);
        if (r < p_sh)               e.sh = 1'b1;
        else if (r < p_sh + p_lg)   e.lg = 1'b1;
        else if (r < flen - 1)      e.req = (((r - p_sh - p_lg) % p_sp) == 0);
        else if (r == flen - 1) begin
            e.fd = 1'b1;
            e.bd = (k == nf - 1);
        end else begin
            e.idx = 8'(k + 1);
        end
        return e;
    endfunction

    function automatic exp_t model_a(int t, int ns, int nf);
        return model(t, ns, nf, 10, 64, 320, 288, 80, 32);
    endfunction

    function automatic exp_t model_b(int t, int ns, int nf);
        return model(t, ns, nf, 1, 1, 1, 1, 1, 1);
    endfunction

    task automatic start_a(int ns, int nf);
        @(negedge clk);
        a_nsym = 16'(ns); a_nframe = 8'(nf); a_send = 1'b1;
        @(posedge clk);
        #1;
        a_send = 1'b0; a_nsym = 16'($urandom); a_nframe = 8'($urandom);
    endtask

    task automatic start_b(int ns, int nf);
        @(negedge clk);
        b_nsym = 16'(ns); b_nframe = 8'(nf); b_send = 1'b1;
        @(posedge clk);
        #1;
        b_send = 1'b0; b_nsym = 16'($urandom); b_nframe = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_send = 0; a_abort = 0; a_nsym = 0; a_nframe = 0;
        b_send = 0; b_abort = 0; b_nsym = 0; b_nframe = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (got_a() !== '0) begin
            failures++; $display("FAIL reset_a got=%h exp=%h", got_a(), 15'h0);
        end
        checks++;
        if (got_b() !== '0) begin
            failures++; $display("FAIL reset_b got=%h exp=%h", got_b(), 15'h0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got_a() !== '0) begin
            failures++; $display("FAIL post_reset_idle got=%h exp=%h", got_a(), 15'h0);
        end
    endtask

    task automatic test_single_frame();
        exp_t e; bit bad = 0;
        start_a(3, 1);
        for (int t = 1; t <= 930; t++) begin
            @(negedge clk);
            e = model_a(t, 3, 1);
            if (!bad) begin
                checks++;
                if (got_a() !== e) begin
                    failures++; bad = 1;
                    $display("FAIL single_frame t=%0d got=%h exp=%h", t, got_a(), e);
                end
            end
        end
    endtask

    task automatic test_two_frames();
        exp_t e; bit bad = 0;
        start_a(1, 2);
        for (int t = 1; t <= 1490; t++) begin
            @(negedge clk);
            e = model_a(t, 1, 2);
            if (!bad) begin
                checks++;
                if (got_a() !== e) begin
                    failures++; bad = 1;
                    $display("FAIL two_frames t=%0d got=%h exp=%h", t, got_a(), e);
                end
            end
        end
    endtask

    task automatic test_zero_counts();
        exp_t e; bit bad = 0;
        start_a(0, 0);
        for (int t = 1; t <= 690; t++) begin
            @(negedge clk);
            e = model_a(t, 0, 0);
            if (!bad) begin
                checks++;
                if (got_a() !== e) begin
                    failures++; bad = 1;
                    $display("FAIL zero_counts t=%0d got=%h exp=%h", t, got_a(), e);
                end
            end
        end
    endtask

    task automatic test_abort();
        exp_t e; bit bad = 0;
        start_a(2, 1);
        for (int t = 1; t <= 205 + 766; t++) begin
            @(negedge clk);
            if (t <= 200)      e = model_a(t, 2, 1);
            else if (t <= 205) e = '0;
            else               e = model_a(t - 205, 1, 1);
            if (!bad) begin
                checks++;
                if (got_a() !== e) begin
                    failures++; bad = 1;
                    $display("FAIL abort t=%0d got=%h exp=%h", t, got_a(), e);
                end
            end
            case (t)
                200: a_abort = 1'b1;
                201: a_abort = 1'b0;
                202: begin a_abort = 1'b1; a_send = 1'b1; end
                203: begin a_abort = 1'b0; a_send = 1'b0; end
                205: begin a_send = 1'b1; a_nsym = 16'd1; a_nframe = 8'd1; end
                206: a_send = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_send_ignored();
        exp_t e; bit bad = 0;
        start_a(3, 1);
        for (int t = 1; t <= 930; t++) begin
            @(negedge clk);
            e = model_a(t, 3, 1);
            if (!bad) begin
                checks++;
                if (got_a() !== e) begin
                    failures++; bad = 1;
                    $display("FAIL send_ignored t=%0d got=%h exp=%h", t, got_a(), e);
                end
            end
            if (t == 500) begin a_send = 1'b1; a_nsym = 16'd7; end
            if (t == 501) a_send = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        exp_t e; bit bad = 0;
        start_a(3, 1);
        for (int t = 1; t <= 700; t++) begin
            @(negedge clk);
            e = model_a(t, 3, 1);
            if (!bad) begin
                checks++;
                if (got_a() !== e) begin
                    failures++; bad = 1;
                    $display("FAIL pre_async_reset t=%0d got=%h exp=%h", t, got_a(), e);
                end
            end
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (got_a() !== '0) begin
            failures++; $display("FAIL async_reset got=%h exp=%h", got_a(), 15'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (got_a() !== '0) begin
                failures++; $display("FAIL after_async_reset t=%0d got=%h exp=%h", t, got_a(), 15'h0);
            end
        end
    endtask

    task automatic test_extreme();
        exp_t e; bit bad = 0;
        start_b(4, 1);
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            e = model_b(t, 4, 1);
            if (!bad) begin
                checks++;
                if (got_b() !== e) begin
                    failures++; bad = 1;
                    $display("FAIL extreme t=%0d got=%h exp=%h", t, got_b(), e);
                end
            end
        end
    endtask

    task automatic test_random_bursts();
        for (int n = 0; n < 4; n++) begin
            int ns, nf, nfe, tend;
            exp_t e; bit bad;
            ns = $urandom_range(0, 3); nf = $urandom_range(0, 3);
            nfe = (nf == 0) ? 1 : nf;
            tend = 10 + 64 + nfe * (320 + 288 + ns * 80 + 1) + (nfe - 1) * 32;
            bad = 0;
            start_a(ns, nf);
            for (int t = 1; t <= tend + 3; t++) begin
                @(negedge clk);
                e = model_a(t, ns, nf);
                if (!bad) begin
                    checks++;
                    if (got_a() !== e) begin
                        failures++; bad = 1;
                        $display("FAIL random_a ns=%0d nf=%0d t=%0d got=%h exp=%h", ns, nf, t, got_a(), e);
                    end
                end
                a_send = (t <= tend) && ($urandom_range(0, 63) == 0);
            end
        end
    endtask

    task automatic test_random_abort();
        for (int n = 0; n < 20; n++) begin
            int ns, nf, nfe, tend, ta;
            exp_t e; bit bad;
            ns = $urandom_range(0, 6); nf = $urandom_range(0, 4);
            nfe = (nf == 0) ? 1 : nf;
            tend = 2 + nfe * (3 + ns) + (nfe - 1);
            ta = ($urandom_range(0, 1) == 1) ? $urandom_range(1, tend) : 0;
            bad = 0;
            start_b(ns, nf);
            for (int t = 1; t <= tend + 3; t++) begin
                @(negedge clk);
                e = (ta != 0 && t > ta) ? exp_t'('0) : model_b(t, ns, nf);
                if (!bad) begin
                    checks++;
                    if (got_b() !== e) begin
                        failures++; bad = 1;
                        $display("FAIL random_b ns=%0d nf=%0d ta=%0d t=%0d got=%h exp=%h", ns, nf, ta, t, got_b(), e);
                    end
                end
                b_abort = (ta != 0 && t == ta);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_two_frames();
        test_zero_counts();
        test_abort();
        test_send_ignored();
        test_async_reset();
        test_extreme();
        test_random_bursts();
        test_random_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_frame_sequencer.md
Name: tx_frame_sequencer

Overview:
Parametrised successor to the transmitter main control unit. It sequences one DMT/OFDM frame, or a burst of frames, for the VLC transmitter: PHY reset, training-sequence guard delay, short preamble, long preamble, then paced data-symbol requests to the MAC. Everything runs on SYS_CLK, with no symbol-clock domain. It adds runtime symbol and frame counts, inter-frame gaps, abort, and status outputs. It sits between the MAC interface and the preamble/IFFT datapath.

Parameters:
PHY_RST_CYCLES, 10, PHY_RST high time in cycles (>=1)
TS_DELAY_CYCLES, 64, guard cycles between PHY reset and short preamble (>=1)
SHORT_LEN, 320, SHORT_ACK high time in cycles (>=1)
LONG_LEN, 288, LONG_ACK high time in cycles (>=1)
SYM_PERIOD, 80, cycles between DATA_REQ pulses, i.e. one OFDM symbol (>=1)
IFG_CYCLES, 32, inter-frame gap inside a burst (>=1)
NSYM_W, 16, width of the symbol count
NFRM_W, 8, width of the frame count

Ports:
SYS_CLK  in  1  system clock
S_MCU_RST  in  1  reset; asynchronous, active-high
SEND_ENABLE  in  1  start request, sampled high on an edge
N_SYM  in  NSYM_W  data symbols per frame; latched at start
N_FRAME  in  NFRM_W  frames per burst; latched at start; 0 is treated as 1
ABORT  in  1  terminate the current burst
PHY_RST  out  1  datapath reset
SHORT_ACK  out  1  short-preamble window
LONG_ACK  out  1  long-preamble window
DATA_REQ  out  1  one-cycle pulse per data symbol
BUSY  out  1  high in every state except IDLE
FRAME_DONE  out  1  one-cycle pulse at the end of each completed frame
BURST_DONE  out  1  one-cycle pulse at the end of the last frame
FRAME_IDX  out  NFRM_W  index of the current frame, 0-based

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - All outputs 0, FRAME_IDX = 0, all counters 0.
  - Internal release is plain synchronous logic; there is no reset synchroniser in this block.
- All outputs are registered and are pure functions of state and counters. No output has a combinational path from an input.
- Timing convention: cycle 0 is the cycle in which SEND_ENABLE is sampled high while in IDLE. On that edge, N_SYM and N_FRAME are latched and FRAME_IDX is cleared.
- States and transitions. Each state lasts exactly its parameter count of cycles.
  - PHY_RESET: PHY_RST = 1, for PHY_RST_CYCLES cycles. Then go to TS_DELAY.
  - TS_DELAY: all strobes 0, for TS_DELAY_CYCLES cycles. Then go to SHORT.
  - SHORT: SHORT_ACK = 1, for SHORT_LEN cycles. Then go to LONG.
  - LONG: LONG_ACK = 1, for LONG_LEN cycles. SHORT_ACK and LONG_ACK never overlap. Then go to DATA, or to FRAME_END if N_SYM == 0.
  - DATA: lasts N_SYM*SYM_PERIOD cycles. DATA_REQ pulses in the first cycle of each SYM_PERIOD slot, giving exactly N_SYM pulses. Then go to FRAME_END.
  - FRAME_END: one cycle. FRAME_DONE = 1.
    - If this is the last frame (FRAME_IDX == N_FRAME-1): BURST_DONE = 1, next state is IDLE.
    - Otherwise: next state is IFG, and FRAME_IDX increments on the exit edge.
  - IFG: all strobes 0, for IFG_CYCLES cycles. Then go to SHORT. PHY_RESET and TS_DELAY run only once per burst.
- SYS_CLK counts:
  - Symbol counter: NSYM_W bits.
  - Slot counter: width ceil(log2(SYM_PERIOD)).
  - Phase counter: sized to the largest of the four duration parameters.
  - Counters never wrap inside a state.
- SEND_ENABLE is ignored whenever BUSY = 1; it is not queued.
- ABORT:
  - Whenever BUSY = 1, ABORT sampled high forces IDLE on the next edge.
  - All outputs 0 in the following cycle. No FRAME_DONE or BURST_DONE is issued.
  - ABORT has priority over every other transition.
  - In IDLE, if SEND_ENABLE and ABORT are both high, the block stays in IDLE.
- BUSY is high from cycle 1 through the FRAME_END cycle of the last frame inclusive.

Test Plan:
- Defaults, N_SYM=3, N_FRAME=1, SEND_ENABLE at cycle 0 -> PHY_RST cycles 1-10; TS_DELAY 11-74; SHORT_ACK 75-394; LONG_ACK 395-682; DATA_REQ pulses at 683, 763, 843; FRAME_DONE and BURST_DONE at 923; BUSY low from 924.
- N_SYM=1, N_FRAME=2 -> DATA_REQ at 683; FRAME_DONE at 763 (BURST_DONE 0); IFG 764-795; SHORT_ACK 796-1115; LONG_ACK 1116-1403; DATA_REQ at 1404; FRAME_DONE and BURST_DONE at 1484; FRAME_IDX = 1 from 764; PHY_RST not reasserted.
- N_SYM=0, N_FRAME=0 -> no DATA_REQ pulse; FRAME_DONE and BURST_DONE at 683; BUSY low at 684.
- ABORT held high in cycle 200 (during SHORT) -> cycle 201: SHORT_ACK=0, BUSY=0, no DONE pulses; a new SEND_ENABLE at 205 restarts with PHY_RST from 206.
- SEND_ENABLE pulsed at cycle 500 mid-burst -> no effect, timing identical to the first scenario. Async S_MCU_RST asserted mid-DATA (cycle 700, between edges) -> all outputs 0 immediately, without waiting for an edge.
- Extreme parameters (SYM_PERIOD=1, all other durations 1) with N_SYM=4 -> DATA_REQ high for 4 consecutive cycles, then FRAME_DONE the next cycle.
